// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with parallel load, decimal wrap pulse and a
// time-multiplexed 7-segment driver with optional leading-zero blanking.
module bcd_updown_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          BLANK_LZ       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sentido,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned       PW       = $clog2(SCAN_DIV);
    localparam int unsigned       IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_ZERO = 7'b0111111;
    localparam logic [6:0]        SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_FIRST = 1;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1100111;
            default: decode = 7'b0111111;
        endcase
    endfunction

    logic [4*DIGITS-1:0] load_clean;
    logic [4*DIGITS-1:0] step_val;
    logic                ripple;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++)
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end

    // ripple leaving the top digit is exactly the decimal wrap condition
    always_comb begin
        step_val = count;
        ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple) begin
                if (!sentido) begin
                    if (count[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                        ripple             = 1'b0;
                    end
                end else begin
                    if (count[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                        ripple             = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: sequential state is assigned with non-blocking (<=) only.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            carry <= 1'b0;
        end else if (load) begin
            count <= load_clean;
            carry <= 1'b0;
        end else if (en) begin
            count <= step_val;
            carry <= ripple;
        end else begin
            carry <= 1'b0;
        end
    end

    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic              scan_tick;
    logic [3:0]        sel_digit;
    logic              upper_nz;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_d;

    assign scan_tick = (pre_q == PW'(SCAN_DIV - 1));

    // seg/an are built from the index being loaded this edge, so an always equals
    // onehot(idx) and the first advance lands SCAN_DIV cycles after reset
    always_comb begin
        idx_d = idx_q;
        if (scan_tick)
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

        sel_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_d)
                sel_digit = count[4*i +: 4];
            if (IW'(i) >= idx_d && count[4*i +: 4] != 4'd0)
                upper_nz = 1'b1;
        end

        seg_d = decode(sel_digit);
        if (BLANK_LZ && idx_d != '0 && !upper_nz)
            seg_d = 7'b0000000;

        an_d        = '0;
        an_d[idx_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            seg   <= SEG_ZERO ^ SEG_POL;
            an    <= AN_FIRST ^ AN_POL;
        end else begin
            pre_q <= scan_tick ? '0 : pre_q + 1'b1;
            idx_q <= idx_d;
            seg   <= seg_d ^ SEG_POL;
            an    <= an_d ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed bench for bcd_updown_display: table of counter vectors plus hand-written
// sequences for segment lag, scan rotation/blanking and active-low polarity.
module tb_bcd_updown_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_en = 1'b0, a_dn = 1'b0, a_ld = 1'b0;
    logic [15:0] a_lv = '0;
    logic [15:0] a_count;
    logic        a_carry;
    logic [6:0]  a_seg;
    logic [3:0]  a_an;

    logic [15:0] l_count;
    logic        l_carry;
    logic [6:0]  l_seg;
    logic [3:0]  l_an;

    logic        s_ld = 1'b0;
    logic [15:0] s_lv = '0;
    logic [15:0] s_count;
    logic        s_carry;
    logic [6:0]  s_seg;
    logic [3:0]  s_an;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bcd_updown_display #(.DIGITS(4)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .sentido(a_dn), .load(a_ld),
        .load_val(a_lv), .count(a_count), .carry(a_carry), .seg(a_seg), .an(a_an));

    bcd_updown_display #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .reset(reset), .en(a_en), .sentido(a_dn), .load(a_ld),
        .load_val(a_lv), .count(l_count), .carry(l_carry), .seg(l_seg), .an(l_an));

    bcd_updown_display #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_s (
        .clk(clk), .reset(reset), .en(1'b0), .sentido(1'b0), .load(s_ld),
        .load_val(s_lv), .count(s_count), .carry(s_carry), .seg(s_seg), .an(s_an));

    typedef struct {
        logic        rst;
        logic        ld;
        logic        en;
        logic        dn;
        logic [15:0] lv;
        logic [15:0] exp_count;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, ld, en, dn, input logic [15:0] lv,
                                input logic [15:0] c, input logic cy);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.dn = dn; v.lv = lv;
        v.exp_count = c; v.exp_carry = cy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic r, ld, e, dn, input logic [15:0] lv);
        @(negedge clk);
        reset = r; a_ld = ld; a_en = e; a_dn = dn; a_lv = lv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] scan_exp(input logic [3:0] an_v);
        case (an_v)
            4'b0001: return 7'b1101101;
            4'b0010: return 7'b0111111;
            4'b0100: return 7'b1001111;
            4'b1000: return 7'b0000000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    initial begin
        logic [3:0] prev_an;
        int         dwell;

        //               rst ld en dn  load_val    count      carry
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0001, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0002, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0003, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0004, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0005, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0006, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0007, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0008, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0009, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0010, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0011, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0012, 1'b0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h9998, 16'h9998, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h9999, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 1'b1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h9999, 1'b1));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h9998, 1'b0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h12F4, 16'h1204, 1'b0));
        vecs.push_back(mk(1, 1, 1, 0, 16'h5555, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h1000, 16'h1000, 1'b0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0999, 1'b0));
        vecs.push_back(mk(0, 1, 0, 0, 16'hAAAA, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0001, 1'b0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h9999, 1'b1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h9999, 1'b0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].dn, vecs[i].lv);
            check($sformatf("vec%0d_count", i), 32'(a_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_carry", i), 32'(a_carry), 32'(vecs[i].exp_carry));
            if (vecs[i].rst) begin
                check($sformatf("vec%0d_reset_seg", i), 32'(a_seg), 32'(7'b0111111));
                check($sformatf("vec%0d_reset_an", i), 32'(a_an), 32'(4'b0001));
                check($sformatf("vec%0d_lowact_seg", i), 32'(l_seg), 32'(7'b1000000));
                check($sformatf("vec%0d_lowact_an", i), 32'(l_an), 32'(4'b1110));
            end
        end

        // seg follows a count change one cycle later
        apply(1, 0, 0, 0, 16'h0000);
        apply(0, 0, 1, 0, 16'h0000);
        check("lag_count", 32'(a_count), 32'(16'h0001));
        check("lag_seg_old", 32'(a_seg), 32'(7'b0111111));
        apply(0, 0, 0, 0, 16'h0000);
        check("lag_seg_new", 32'(a_seg), 32'(7'b0000110));
        check("lag_an", 32'(a_an), 32'(4'b0001));

        // scan: SCAN_DIV=4, count 0305, leading zero blanked
        apply(1, 0, 0, 0, 16'h0000);
        check("scan_reset_an", 32'(s_an), 32'(4'b0001));
        prev_an = 4'b0001;
        dwell   = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            reset = 1'b0;
            s_ld  = (k == 1);
            s_lv  = 16'h0305;
            @(posedge clk);
            #1;
            if (s_an == prev_an) begin
                dwell++;
            end else begin
                check($sformatf("scan_dwell_k%0d", k), 32'(dwell), 32'd4);
                check($sformatf("scan_rotate_k%0d", k), 32'(s_an), 32'({prev_an[2:0], prev_an[3]}));
                prev_an = s_an;
                dwell   = 1;
            end
            if (k >= 2)
                check($sformatf("scan_seg_k%0d", k), 32'(s_seg), 32'(scan_exp(s_an)));
        end
        check("scan_count", 32'(s_count), 32'(16'h0305));
        check("scan_carry", 32'(s_carry), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
